memory_controller: RTL and testbench

MEMORY_CONTROLLER -- requirements
Module: memory_controller

---
 rtl/memory_controller_pkg.sv | 28 ++
 rtl/memory_controller_if.sv | 35 +++
 rtl/memory_controller_byte_seq.sv | 70 +++++++
 rtl/memory_controller.sv | 180 ++++++++++++++++++
 tb/tb_memory_controller.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/memory_controller_pkg.sv
// rtl/memory_controller_pkg.sv - state encoding, access size codes and I/O address match for memory_controller
package memory_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_IFETCH = 3'd1,
        ST_DREAD  = 3'd2,
        ST_DWRITE = 3'd3,
        ST_IOWAIT = 3'd4
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // dataAddr[17:16] value that selects the UART window
    localparam logic [1:0] IO_ADDR_SEL = 2'b11;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            SIZE_WORD: return 3'd4;
            default:   return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/memory_controller_if.sv
// rtl/memory_controller_if.sv - memory, fetch and load/store bus bundle for memory_controller
interface memory_controller_if #(parameter int BLOCK_WIDTH = 4);
    localparam int BLOCK_SIZE = 2 ** BLOCK_WIDTH;

    logic                    readyIn;
    logic                    clearIn;
    logic [7:0]              memIn;
    logic [7:0]              memOut;
    logic [31:0]             memAddr;
    logic                    memWrite;
    logic                    ioBufferFull;
    logic                    instrReq;
    logic [31:0]             instrAddr;
    logic                    instrDone;
    logic [8*BLOCK_SIZE-1:0] instrLine;
    logic                    dataReq;
    logic                    dataWrite;
    logic [1:0]              dataSize;
    logic [31:0]             dataAddr;
    logic [31:0]             dataIn;
    logic                    dataDone;
    logic [31:0]             dataOut;

    modport master (
        output readyIn, clearIn, memIn, ioBufferFull,
        output instrReq, instrAddr, dataReq, dataWrite, dataSize, dataAddr, dataIn,
        input  memOut, memAddr, memWrite, instrDone, instrLine, dataDone, dataOut
    );

    modport slave (
        input  readyIn, clearIn, memIn, ioBufferFull,
        input  instrReq, instrAddr, dataReq, dataWrite, dataSize, dataAddr, dataIn,
        output memOut, memAddr, memWrite, instrDone, instrLine, dataDone, dataOut
    );
endinterface

// File: rtl/memory_controller_byte_seq.sv
// rtl/memory_controller_byte_seq.sv - mem_byte_sequencer: byte counter, address generator and read assembler
module mem_byte_sequencer #(
    parameter int BUF_BYTES = 16,
    parameter int CW        = 5
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [31:0]            base,
    input  logic [31:0]            wdata,
    input  logic                   advance,
    input  logic                   rd_issue,
    input  logic [7:0]             rdata,
    output logic [CW-1:0]          cnt,
    output logic [31:0]            addr,
    output logic [7:0]             wbyte,
    output logic [8*BUF_BYTES-1:0] assembled
);
    logic [31:0]            base_q;
    logic [31:0]            wdata_q;
    logic [8*BUF_BYTES-1:0] buf_q;
    logic                   pend;
    logic [CW-1:0]          pend_idx;

    // Capture follows the address by exactly one clock even across a freeze,
    // because memIn only reflects the address driven on the previous edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            base_q   <= '0;
            wdata_q  <= '0;
            buf_q    <= '0;
            pend     <= 1'b0;
            pend_idx <= '0;
            cnt      <= '0;
        end else begin
            pend     <= rd_issue;
            pend_idx <= cnt;
            for (int i = 0; i < BUF_BYTES; i++) begin
                if (pend && pend_idx == CW'(i)) buf_q[8*i +: 8] <= rdata;
            end
            if (start) begin
                base_q  <= base;
                wdata_q <= wdata;
                buf_q   <= '0;
                cnt     <= '0;
            end else if (advance) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_comb begin
        assembled = buf_q;
        for (int i = 0; i < BUF_BYTES; i++) begin
            if (pend && pend_idx == CW'(i)) assembled[8*i +: 8] = rdata;
        end
    end

    always_comb begin
        wbyte = wdata_q[7:0];
        case (cnt[1:0])
            2'd1:    wbyte = wdata_q[15:8];
            2'd2:    wbyte = wdata_q[23:16];
            2'd3:    wbyte = wdata_q[31:24];
            default: wbyte = wdata_q[7:0];
        endcase
    end

    assign addr = base_q + 32'(cnt);
endmodule

// File: rtl/memory_controller.sv
// rtl/memory_controller.sv - byte-wide memory arbiter for instruction lines and data accesses; MEM_CTRL_IO_STALL_EN enables UART back-pressure
module memory_controller
    import memory_controller_pkg::*;
#(
    parameter int BLOCK_WIDTH = 4
) (
    input logic          clockIn,
    input logic          resetIn,
    memory_controller_if.slave bus
);
    localparam int BLOCK_SIZE = 2 ** BLOCK_WIDTH;
    localparam int BUF_BYTES  = (BLOCK_SIZE > 4) ? BLOCK_SIZE : 4;
    localparam int CW         = $clog2(BUF_BYTES) + 1;

    state_t                  state, next_state;
    logic                    gap_q, gap_n;
    logic                    io_q, io_n;
    logic [CW-1:0]           len_q, len_n;
    logic                    last_data_q, last_data_n;
    logic                    idone_q, idone_n;
    logic                    ddone_q, ddone_n;
    logic [8*BLOCK_SIZE-1:0] line_q, line_n;
    logic [31:0]             dout_q, dout_n;

    logic                    seq_start, seq_advance;
    logic [31:0]             seq_base, seq_wdata, seq_addr;
    logic [CW-1:0]           seq_cnt;
    logic [7:0]              seq_wbyte;
    logic [8*BUF_BYTES-1:0]  seq_assembled;
    logic                    drive_rd, drive_wr;
    logic                    ireq, dreq;
    logic                    io_hit, io_full;

`ifdef MEM_CTRL_IO_STALL_EN
    assign io_hit  = bus.dataWrite && (bus.dataAddr[17:16] == IO_ADDR_SEL);
    assign io_full = bus.ioBufferFull;
`else
    logic unused_io_full;
    assign unused_io_full = bus.ioBufferFull;
    assign io_hit         = 1'b0;
    assign io_full        = 1'b0;
`endif

    // A requester stays high through its done cycle; masking it here stops a re-grant.
    assign ireq = bus.instrReq && !idone_q;
    assign dreq = bus.dataReq && !ddone_q;

    always_comb begin
        next_state  = state;
        gap_n       = gap_q;
        io_n        = io_q;
        len_n       = len_q;
        last_data_n = last_data_q;
        idone_n     = 1'b0;
        ddone_n     = 1'b0;
        line_n      = line_q;
        dout_n      = dout_q;
        seq_start   = 1'b0;
        seq_advance = 1'b0;
        seq_base    = '0;
        seq_wdata   = '0;
        case (state)
            ST_IDLE: begin
                if (ireq && (last_data_q || !dreq)) begin
                    seq_start   = 1'b1;
                    seq_base    = bus.instrAddr & ~32'(BLOCK_SIZE - 1);
                    len_n       = CW'(BLOCK_SIZE);
                    last_data_n = 1'b0;
                    io_n        = 1'b0;
                    gap_n       = 1'b0;
                    next_state  = ST_IFETCH;
                end else if (dreq) begin
                    seq_start   = 1'b1;
                    seq_base    = bus.dataAddr;
                    seq_wdata   = bus.dataIn;
                    len_n       = CW'(size_bytes(bus.dataSize));
                    last_data_n = 1'b1;
                    io_n        = io_hit;
                    gap_n       = 1'b0;
                    if (!bus.dataWrite)        next_state = ST_DREAD;
                    else if (io_hit && io_full) next_state = ST_IOWAIT;
                    else                       next_state = ST_DWRITE;
                end
            end
            ST_IFETCH, ST_DREAD: begin
                if (bus.clearIn) begin
                    next_state = ST_IDLE;
                end else if (seq_cnt == len_q) begin
                    next_state = ST_IDLE;
                    if (state == ST_IFETCH) begin
                        idone_n = 1'b1;
                        line_n  = seq_assembled[8*BLOCK_SIZE-1:0];
                    end else begin
                        ddone_n = 1'b1;
                        dout_n  = seq_assembled[31:0];
                    end
                end else begin
                    seq_advance = 1'b1;
                end
            end
            ST_DWRITE: begin
                if (!gap_q) begin
                    seq_advance = 1'b1;
                    if (io_q) begin
                        gap_n = 1'b1;
                    end else if (seq_cnt == len_q - CW'(1)) begin
                        ddone_n    = 1'b1;
                        next_state = ST_IDLE;
                    end
                end else begin
                    gap_n = 1'b0;
                    if (seq_cnt == len_q) begin
                        ddone_n    = 1'b1;
                        next_state = ST_IDLE;
                    end else if (io_full) begin
                        next_state = ST_IOWAIT;
                    end
                end
            end
            ST_IOWAIT: begin
                if (!io_full) next_state = ST_DWRITE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clockIn) begin
        if (!resetIn) begin
            state       <= ST_IDLE;
            gap_q       <= 1'b0;
            io_q        <= 1'b0;
            len_q       <= '0;
            last_data_q <= 1'b0;
            idone_q     <= 1'b0;
            ddone_q     <= 1'b0;
            line_q      <= '0;
            dout_q      <= '0;
        end else if (bus.readyIn) begin
            state       <= next_state;
            gap_q       <= gap_n;
            io_q        <= io_n;
            len_q       <= len_n;
            last_data_q <= last_data_n;
            idone_q     <= idone_n;
            ddone_q     <= ddone_n;
            line_q      <= line_n;
            dout_q      <= dout_n;
        end
    end

    assign drive_rd = bus.readyIn && (state == ST_IFETCH || state == ST_DREAD) && (seq_cnt < len_q);
    assign drive_wr = bus.readyIn && (state == ST_DWRITE) && !gap_q;

    mem_byte_sequencer #(
        .BUF_BYTES (BUF_BYTES),
        .CW        (CW)
    ) u_seq (
        .clk       (clockIn),
        .resetn    (resetIn),
        .start     (seq_start && bus.readyIn),
        .base      (seq_base),
        .wdata     (seq_wdata),
        .advance   (seq_advance && bus.readyIn),
        .rd_issue  (drive_rd),
        .rdata     (bus.memIn),
        .cnt       (seq_cnt),
        .addr      (seq_addr),
        .wbyte     (seq_wbyte),
        .assembled (seq_assembled)
    );

    assign bus.memWrite  = drive_wr;
    assign bus.memAddr   = (drive_wr || drive_rd) ? seq_addr : 32'd0;
    assign bus.memOut    = drive_wr ? seq_wbyte : 8'd0;
    // A done pulse that lands in a frozen cycle is held and shown once on resume.
    assign bus.instrDone = idone_q && bus.readyIn;
    assign bus.dataDone  = ddone_q && bus.readyIn;
    assign bus.instrLine = line_q;
    assign bus.dataOut   = dout_q;
endmodule

// File: tb/tb_memory_controller.sv
// tb/tb_memory_controller.sv - directed self-checking bench for memory_controller; expectations follow MEM_CTRL_IO_STALL_EN
module tb_memory_controller;
    import memory_controller_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    memory_controller_if #(.BLOCK_WIDTH(4)) bus();
    memory_controller #(.BLOCK_WIDTH(4)) dut (.clockIn(clk), .resetIn(rstn), .bus(bus));

    // Memory returns addr[7:0]^A5 one cycle after the address is driven
    always @(posedge clk) bus.memIn <= bus.memAddr[7:0] ^ 8'hA5;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [31:0] tr_addr [0:63];
    logic        tr_wr   [0:63];
    logic [7:0]  tr_out  [0:63];
    int          tcyc;
    int          idone_cyc, n_idone, n_ddone;
    int          ddone_cyc [0:3];
    logic [31:0] dout_at   [0:3];

    task automatic start_test();
        tcyc = 0;
        idone_cyc = -1;
        n_idone = 0;
        n_ddone = 0;
        for (int i = 0; i < 4; i++) begin
            ddone_cyc[i] = -1;
            dout_at[i] = '0;
        end
        for (int i = 0; i < 64; i++) begin
            tr_addr[i] = '0;
            tr_wr[i] = 1'b0;
            tr_out[i] = '0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        tcyc++;
        if (tcyc < 64) begin
            tr_addr[tcyc] = bus.memAddr;
            tr_wr[tcyc]   = bus.memWrite;
            tr_out[tcyc]  = bus.memOut;
        end
        if (bus.instrDone === 1'b1) begin
            if (n_idone == 0) idone_cyc = tcyc;
            n_idone++;
            bus.instrReq = 1'b0;
        end
        if (bus.dataDone === 1'b1) begin
            if (n_ddone < 4) begin
                ddone_cyc[n_ddone] = tcyc;
                dout_at[n_ddone] = bus.dataOut;
            end
            n_ddone++;
            bus.dataReq = 1'b0;
        end
    endtask

    task automatic data_req(input logic wr, input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        bus.dataReq   = 1'b1;
        bus.dataWrite = wr;
        bus.dataSize  = size;
        bus.dataAddr  = addr;
        bus.dataIn    = wdata;
    endtask

    initial begin
        rstn = 1'b0;
        bus.readyIn = 1'b1;
        bus.clearIn = 1'b0;
        bus.ioBufferFull = 1'b0;
        bus.instrReq = 1'b0;
        bus.instrAddr = '0;
        bus.dataReq = 1'b0;
        bus.dataWrite = 1'b0;
        bus.dataSize = 2'b00;
        bus.dataAddr = '0;
        bus.dataIn = '0;
        start_test();
        repeat (3) tick();
        rstn = 1'b1;
        tick();
        check("rst_bus", {bus.memWrite, bus.memAddr, bus.memOut, bus.instrDone, bus.dataDone}, '0);
        check("rst_line", bus.instrLine, '0);
        check("rst_dout", bus.dataOut, '0);

        // Line fetch from an unaligned address
        start_test();
        bus.instrReq = 1'b1;
        bus.instrAddr = 32'h1004;
        repeat (20) tick();
        check("if_addr1", tr_addr[1], 32'h1000);
        check("if_addr16", tr_addr[16], 32'h100F);
        check("if_addr17", tr_addr[17], 32'h0);
        check("if_done_cyc", idone_cyc, 18);
        check("if_done_cnt", n_idone, 1);
        check("if_line", bus.instrLine, 128'hAAABA8A9_AEAFACAD_A2A3A0A1_A6A7A4A5);

        // Simultaneous requests, then a further data request behind the fetch
        start_test();
        bus.instrReq = 1'b1;
        bus.instrAddr = 32'h40;
        data_req(1'b0, SIZE_BYTE, 32'h2003, 32'h0);
        for (int i = 0; i < 28; i++) begin
            tick();
            if (tcyc == 3) data_req(1'b0, SIZE_HALF, 32'h3000, 32'h0);
        end
        check("arb_d_addr", tr_addr[1], 32'h2003);
        check("arb_d_done", ddone_cyc[0], 3);
        check("arb_d_val", dout_at[0], 32'h000000A6);
        check("arb_i_addr", tr_addr[4], 32'h40);
        check("arb_i_done", idone_cyc, 21);
        check("arb_d2_addr", tr_addr[22], 32'h3000);
        check("arb_d2_done", ddone_cyc[1], 25);
        check("arb_d2_val", dout_at[1], 32'h0000A4A5);

        // Word store
        start_test();
        data_req(1'b1, SIZE_WORD, 32'h200, 32'hDEADBEEF);
        repeat (8) tick();
        check("st_b0", {tr_wr[1], tr_addr[1], tr_out[1]}, {1'b1, 32'h200, 8'hEF});
        check("st_b1", {tr_wr[2], tr_addr[2], tr_out[2]}, {1'b1, 32'h201, 8'hBE});
        check("st_b3", {tr_wr[4], tr_addr[4], tr_out[4]}, {1'b1, 32'h203, 8'hDE});
        check("st_after", tr_wr[5], 1'b0);
        check("st_done", ddone_cyc[0], 5);

        // Flush in cycle 5 of a line fetch
        start_test();
        bus.instrReq = 1'b1;
        bus.instrAddr = 32'h500;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (tcyc == 5) begin
                bus.clearIn = 1'b1;
                bus.instrReq = 1'b0;
            end
            if (tcyc == 6) bus.clearIn = 1'b0;
        end
        check("clr_if_a5", tr_addr[5], 32'h504);
        check("clr_if_a6", tr_addr[6], 32'h0);
        check("clr_if_nodone", n_idone, 0);

        // Flush held through a store, including its completing edge
        start_test();
        data_req(1'b1, SIZE_WORD, 32'h600, 32'h11223344);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (tcyc == 1) bus.clearIn = 1'b1;
            if (tcyc == 5) bus.clearIn = 1'b0;
        end
        check("clr_st_b3", {tr_wr[4], tr_addr[4], tr_out[4]}, {1'b1, 32'h603, 8'h11});
        check("clr_st_done", ddone_cyc[0], 5);

        // Byte store into the UART window with the buffer full for three edges
        start_test();
        data_req(1'b1, SIZE_BYTE, 32'h30000, 32'h41);
        bus.ioBufferFull = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (tcyc == 3) bus.ioBufferFull = 1'b0;
        end
`ifdef MEM_CTRL_IO_STALL_EN
        check("io_wait1", {tr_wr[1], tr_addr[1]}, '0);
        check("io_wait3", {tr_wr[3], tr_addr[3]}, '0);
        check("io_write", {tr_wr[4], tr_addr[4], tr_out[4]}, {1'b1, 32'h30000, 8'h41});
        check("io_gap", tr_wr[5], 1'b0);
        check("io_done", ddone_cyc[0], 6);
`else
        check("io_write", {tr_wr[1], tr_addr[1], tr_out[1]}, {1'b1, 32'h30000, 8'h41});
        check("io_after", tr_wr[2], 1'b0);
        check("io_done", ddone_cyc[0], 2);
`endif
        check("io_done_cnt", n_ddone, 1);

        // Word load frozen for four edges
        start_test();
        data_req(1'b0, SIZE_WORD, 32'h7000, 32'h0);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (tcyc == 2) bus.readyIn = 1'b0;
            if (tcyc == 6) bus.readyIn = 1'b1;
        end
        check("frz_a1", tr_addr[1], 32'h7000);
        check("frz_idle_bus", {tr_wr[4], tr_addr[4]}, '0);
        check("frz_a7", tr_addr[7], 32'h7002);
        check("frz_done", ddone_cyc[0], 10);
        check("frz_val", dout_at[0], 32'hA6A7A4A5);

        // Reset in the middle of a store
        start_test();
        data_req(1'b1, SIZE_WORD, 32'h800, 32'hCAFEF00D);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (tcyc == 2) begin
                rstn = 1'b0;
                bus.dataReq = 1'b0;
            end
            if (tcyc == 3) rstn = 1'b1;
        end
        check("rst_wr_b1", {tr_wr[2], tr_addr[2], tr_out[2]}, {1'b1, 32'h801, 8'hF0});
        check("rst_wr_bus", {tr_wr[3], tr_addr[3], tr_out[3]}, '0);
        check("rst_wr_nodone", n_ddone, 0);
        check("rst_wr_dout", bus.dataOut, '0);
        check("rst_wr_line", bus.instrLine, '0);
        check("rst_wr_state", dut.state, ST_IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
